// File: rtl/pio_ext_irq_servicer_if.sv
// Bus bundle between the interrupt servicer (master) and a PIO slave.
//   address    : PIO register select (master -> slave)
//   chipselect : access strobe (master -> slave)
//   write_n    : active-low write qualifier (master -> slave)
//   writedata  : write data (master -> slave)
//   readdata   : read data, valid one cycle after the address (slave -> master)
//   irq        : level interrupt from the PIO (slave -> master)
interface pio_ext_irq_servicer_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

endinterface

// File: rtl/pio_ext_irq_servicer.sv
// Services a PIO edge-capture interrupt: initialises the PIO (unmask bit 0,
// clear edge capture), then on irq or a poll timeout reads the edge-capture
// register, clears and counts a captured edge, and samples the data register.
// Ports:
//   clk, reset   : single clock, synchronous active-high reset
//   pio          : master side of the PIO bus bundle (incl. irq, readdata)
//   clear_count  : single-cycle request to zero event_count
//   event_count  : saturating count of captured rising edges
//   event_strobe : one-cycle pulse per counted edge
//   ext_level    : last sampled PIO data register bit 0
//   busy         : high in every state except IDLE
module pio_ext_irq_servicer #(
  parameter int unsigned POLL_PERIOD = 1024,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pio_ext_irq_servicer_if.master pio,
  input  logic                   clear_count,
  output logic [CNT_WIDTH-1:0]   event_count,
  output logic                   event_strobe,
  output logic                   ext_level,
  output logic                   busy
);

  localparam int unsigned POLL_W = (POLL_PERIOD > 1) ? int'($clog2(POLL_PERIOD)) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST =
    POLL_W'((POLL_PERIOD == 0) ? 0 : POLL_PERIOD - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_INIT_MASK,
    S_INIT_CLR,
    S_IDLE,
    S_RD_EDGE,
    S_RD_EDGE_WAIT,
    S_CLR_EDGE,
    S_RD_DATA,
    S_RD_DATA_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [1:0]           address_q, address_d;
  logic                 chipselect_q, chipselect_d;
  logic                 write_n_q, write_n_d;
  logic [31:0]          writedata_q, writedata_d;
  logic                 event_strobe_q, event_strobe_d;
  logic                 busy_q, busy_d;
  logic                 ext_level_q, ext_level_d;
  logic [CNT_WIDTH-1:0] event_count_q, event_count_d;
  logic [POLL_W-1:0]    poll_cnt_q, poll_cnt_d;

  logic poll_hit;
  logic edge_inc;

  assign poll_hit = (POLL_PERIOD != 0) && (poll_cnt_q == POLL_LAST);
  assign edge_inc = (state_q == S_CLR_EDGE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT_MASK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // Bus outputs are idle straight out of reset; stay here until the mask
      // write has actually been driven for a cycle.
      S_INIT_MASK:    state_d = chipselect_q ? S_INIT_CLR : S_INIT_MASK;
      S_INIT_CLR:     state_d = S_IDLE;
      S_IDLE:         if (pio.irq || poll_hit) state_d = S_RD_EDGE;
      S_RD_EDGE:      state_d = S_RD_EDGE_WAIT;
      S_RD_EDGE_WAIT: state_d = pio.readdata[0] ? S_CLR_EDGE : S_RD_DATA;
      S_CLR_EDGE:     state_d = S_RD_DATA;
      S_RD_DATA:      state_d = S_RD_DATA_WAIT;
      S_RD_DATA_WAIT: state_d = S_IDLE;
      default:        state_d = S_INIT_MASK;
    endcase
  end

  // Output and datapath logic; bus outputs decode the upcoming state so the
  // registered bus lines up with the state that owns the access.
  always_comb begin
    chipselect_d   = 1'b0;
    write_n_d      = 1'b1;
    address_d      = ADDR_DATA;
    writedata_d    = 32'd0;
    event_strobe_d = 1'b0;
    busy_d         = (state_d != S_IDLE);

    unique case (state_d)
      S_INIT_MASK: begin
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        address_d    = ADDR_MASK;
        writedata_d  = 32'd1;
      end
      S_INIT_CLR: begin
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        address_d    = ADDR_EDGE;
        writedata_d  = 32'd1;
      end
      S_RD_EDGE: begin
        chipselect_d = 1'b1;
        address_d    = ADDR_EDGE;
      end
      S_RD_EDGE_WAIT: begin
        address_d    = ADDR_EDGE;
      end
      S_CLR_EDGE: begin
        chipselect_d   = 1'b1;
        write_n_d      = 1'b0;
        address_d      = ADDR_EDGE;
        writedata_d    = 32'd1;
        event_strobe_d = 1'b1;
      end
      S_RD_DATA: begin
        chipselect_d = 1'b1;
        address_d    = ADDR_DATA;
      end
      default: begin
      end
    endcase

    // Poll counter only runs while staying in IDLE.
    poll_cnt_d = '0;
    if ((state_q == S_IDLE) && (state_d == S_IDLE)) begin
      poll_cnt_d = poll_cnt_q + POLL_W'(1);
    end

    // A clear coincident with an increment leaves the new edge counted.
    event_count_d = event_count_q;
    if (clear_count) begin
      event_count_d = edge_inc ? CNT_WIDTH'(1) : '0;
    end else if (edge_inc && (event_count_q != '1)) begin
      event_count_d = event_count_q + CNT_WIDTH'(1);
    end

    ext_level_d = ext_level_q;
    if (state_q == S_RD_DATA_WAIT) begin
      ext_level_d = pio.readdata[0];
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      chipselect_q   <= 1'b0;
      write_n_q      <= 1'b1;
      address_q      <= ADDR_DATA;
      writedata_q    <= 32'd0;
      event_strobe_q <= 1'b0;
      busy_q         <= 1'b1;
      ext_level_q    <= 1'b0;
      event_count_q  <= '0;
      poll_cnt_q     <= '0;
    end else begin
      chipselect_q   <= chipselect_d;
      write_n_q      <= write_n_d;
      address_q      <= address_d;
      writedata_q    <= writedata_d;
      event_strobe_q <= event_strobe_d;
      busy_q         <= busy_d;
      ext_level_q    <= ext_level_d;
      event_count_q  <= event_count_d;
      poll_cnt_q     <= poll_cnt_d;
    end
  end

  assign pio.chipselect = chipselect_q;
  assign pio.write_n    = write_n_q;
  assign pio.address    = address_q;
  assign pio.writedata  = writedata_q;
  assign event_strobe   = event_strobe_q;
  assign busy           = busy_q;
  assign ext_level      = ext_level_q;
  assign event_count    = event_count_q;

endmodule
